// File: rtl/instruction_encoder.sv
// RV32I instruction packer: turns decoded fields plus a signed immediate into a
// 32-bit word and streams it into instruction memory at an auto-incrementing address.
module instruction_encoder #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [2:0]            fmt_i,
  input  logic [6:0]            opcode_i,
  input  logic [4:0]            rd_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  output logic                  wr_valid_o,
  input  logic                  wr_ready_i,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  err_o,
  output logic [7:0]            err_cnt_o
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  logic                  wr_valid_q, wr_valid_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  err_q, err_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept;
  logic        transfer;

  // Format packing and immediate range check; unknown formats stay illegal.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b0;
    case (fmt_e'(fmt_i))
      FMT_R: begin
        enc_word  = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        enc_legal = 1'b1;
      end
      FMT_I: begin
        enc_word  = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        enc_legal = (&imm_i[31:11]) | ~(|imm_i[31:11]);
      end
      FMT_S: begin
        enc_word  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        enc_legal = (&imm_i[31:11]) | ~(|imm_i[31:11]);
      end
      FMT_B: begin
        enc_word  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                     imm_i[4:1], imm_i[11], opcode_i};
        enc_legal = ((&imm_i[31:12]) | ~(|imm_i[31:12])) & ~imm_i[0];
      end
      FMT_U: begin
        enc_word  = {imm_i[31:12], rd_i, opcode_i};
        enc_legal = ~(|imm_i[11:0]);
      end
      FMT_J: begin
        enc_word  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        enc_legal = ((&imm_i[31:20]) | ~(|imm_i[31:20])) & ~imm_i[0];
      end
      default: begin
        enc_word  = '0;
        enc_legal = 1'b0;
      end
    endcase
  end

  assign in_ready_o = ~clear_i & (~wr_valid_q | wr_ready_i);
  assign accept     = in_valid_i & in_ready_o;
  assign transfer   = wr_valid_q & wr_ready_i;

  // A new word loaded in the same cycle as a drain lands on the advanced address.
  always_comb begin
    wr_valid_d = wr_valid_q;
    wr_data_d  = wr_data_q;
    wr_addr_d  = wr_addr_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    if (clear_i) begin
      wr_valid_d = 1'b0;
      wr_data_d  = '0;
      wr_addr_d  = BASE_ADDR;
      err_cnt_d  = '0;
    end else begin
      if (transfer) begin
        wr_addr_d  = wr_addr_q + ADDR_WIDTH'(4);
        wr_valid_d = 1'b0;
      end
      if (accept && enc_legal) begin
        wr_valid_d = 1'b1;
        wr_data_d  = enc_word;
      end
      if (accept && !enc_legal) begin
        err_d = 1'b1;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_valid_q <= 1'b0;
      wr_data_q  <= '0;
      wr_addr_q  <= BASE_ADDR;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      wr_valid_q <= wr_valid_d;
      wr_data_q  <= wr_data_d;
      wr_addr_q  <= wr_addr_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign wr_valid_o = wr_valid_q;
  assign wr_data_o  = wr_data_q;
  assign wr_addr_o  = wr_addr_q;
  assign err_o      = err_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Randomized and directed bench for instruction_encoder against a cycle-level
// reference model that encodes from the RV32I field rules with plain arithmetic.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        clearI;
  logic        inValid;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        wrReady;

  logic        inReady, wrValid, err;
  logic [31:0] wrAddr, wrData;
  logic [7:0]  errCnt;

  logic        inReadyW, wrValidW, errW;
  logic [3:0]  wrAddrW;
  logic [31:0] wrDataW;
  logic [7:0]  errCntW;

  int vectors = 0;
  int miscompares = 0;

  bit          mValid;
  logic [31:0] mData;
  logic [31:0] mAddr;
  logic [3:0]  mAddrW;
  bit          mErr;
  int          mCnt;

  logic [31:0] boundaryImm [20];

  instruction_encoder dut (
    .clk(clk), .rst(rst), .clear_i(clearI),
    .in_valid_i(inValid), .in_ready_o(inReady),
    .fmt_i(fmt), .opcode_i(opcode), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
    .funct3_i(funct3), .funct7_i(funct7), .imm_i(imm),
    .wr_valid_o(wrValid), .wr_ready_i(wrReady),
    .wr_addr_o(wrAddr), .wr_data_o(wrData),
    .err_o(err), .err_cnt_o(errCnt)
  );

  instruction_encoder #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BASE_ADDR(4'hC)) dutWrap (
    .clk(clk), .rst(rst), .clear_i(clearI),
    .in_valid_i(inValid), .in_ready_o(inReadyW),
    .fmt_i(fmt), .opcode_i(opcode), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
    .funct3_i(funct3), .funct7_i(funct7), .imm_i(imm),
    .wr_valid_o(wrValidW), .wr_ready_i(wrReady),
    .wr_addr_o(wrAddrW), .wr_data_o(wrDataW),
    .err_o(errW), .err_cnt_o(errCntW)
  );

  always #5 clk = ~clk;

  // Reference encoder: each immediate slice is extracted by shift/mask and
  // the legal ranges are plain signed bounds.
  function automatic logic [32:0] modelEncode(input logic [2:0] f, input logic [6:0] op,
                                               input logic [4:0] d, input logic [4:0] s1,
                                               input logic [4:0] s2, input logic [2:0] f3,
                                               input logic [6:0] f7, input logic [31:0] im);
    int          s;
    logic [31:0] w;
    bit          ok;
    s  = signed'(im);
    w  = 32'h0;
    ok = 1'b0;
    case (f)
      3'd0: begin
        w  = (32'(f7) << 25) + (32'(s2) << 20) + (32'(s1) << 15) + (32'(f3) << 12) + (32'(d) << 7);
        ok = 1'b1;
      end
      3'd1: begin
        w  = ((im & 32'hFFF) << 20) + (32'(s1) << 15) + (32'(f3) << 12) + (32'(d) << 7);
        ok = (s >= -2048) && (s <= 2047);
      end
      3'd2: begin
        w  = (((im >> 5) & 32'h7F) << 25) + (32'(s2) << 20) + (32'(s1) << 15)
           + (32'(f3) << 12) + ((im & 32'h1F) << 7);
        ok = (s >= -2048) && (s <= 2047);
      end
      3'd3: begin
        w  = (((im >> 12) & 32'h1) << 31) + (((im >> 5) & 32'h3F) << 25) + (32'(s2) << 20)
           + (32'(s1) << 15) + (32'(f3) << 12) + (((im >> 1) & 32'hF) << 8)
           + (((im >> 11) & 32'h1) << 7);
        ok = (s >= -4096) && (s <= 4095) && ((s % 2) == 0);
      end
      3'd4: begin
        w  = (im & 32'hFFFFF000) + (32'(d) << 7);
        ok = (im % 4096) == 0;
      end
      3'd5: begin
        w  = (((im >> 20) & 32'h1) << 31) + (((im >> 1) & 32'h3FF) << 21)
           + (((im >> 11) & 32'h1) << 20) + (((im >> 12) & 32'hFF) << 12) + (32'(d) << 7);
        ok = (s >= -1048576) && (s <= 1048575) && ((s % 2) == 0);
      end
      default: ok = 1'b0;
    endcase
    w = w + 32'(op);
    return {ok, w};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("in_ready", 32'(inReady), 32'(!clearI && (!mValid || wrReady)));
    checkOutput("wr_valid", 32'(wrValid), 32'(mValid));
    if (mValid) begin
      checkOutput("wr_addr", wrAddr, mAddr);
      checkOutput("wr_data", wrData, mData);
      checkOutput("wr_addr_wrap", 32'(wrAddrW), 32'(mAddrW));
    end
    checkOutput("err", 32'(err), 32'(mErr));
    checkOutput("err_cnt", 32'(errCnt), 32'(mCnt));
  endtask

  task automatic resetModel();
    mValid = 1'b0;
    mData  = 32'h0;
    mAddr  = 32'h0;
    mAddrW = 4'hC;
    mErr   = 1'b0;
    mCnt   = 0;
  endtask

  // Drives one cycle of inputs (called at a falling edge), advances the model,
  // then checks the DUT at the next falling edge.
  task automatic applyStimulus(input bit v, input logic [2:0] f, input logic [6:0] op,
                               input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                               input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im,
                               input bit rdy, input bit clr);
    logic [32:0] enc;
    bit          ready;
    bit          acc;
    bit          xfer;
    inValid = v; fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im; wrReady = rdy; clearI = clr;
    enc   = modelEncode(f, op, d, s1, s2, f3, f7, im);
    ready = !clr && (!mValid || rdy);
    acc   = v && ready;
    xfer  = mValid && rdy;
    if (clr) begin
      mValid = 1'b0;
      mAddr  = 32'h0;
      mAddrW = 4'hC;
      mCnt   = 0;
      mErr   = 1'b0;
    end else begin
      if (xfer) begin
        mAddr  = mAddr + 32'd4;
        mAddrW = mAddrW + 4'd4;
        mValid = 1'b0;
      end
      mErr = acc && !enc[32];
      if (mErr && mCnt < 255) mCnt++;
      if (acc && enc[32]) begin
        mValid = 1'b1;
        mData  = enc[31:0];
      end
    end
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  task automatic idle(input bit rdy);
    applyStimulus(1'b0, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, rdy, 1'b0);
  endtask

  task automatic sendR(input bit rdy);
    applyStimulus(1'b1, 3'd0, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  3'($urandom), 7'($urandom), $urandom, rdy, 1'b0);
  endtask

  task automatic doClear();
    applyStimulus(1'b0, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 1'b0, 1'b1);
  endtask

  function automatic logic [31:0] randImm();
    logic [31:0] r;
    case ($urandom_range(0, 5))
      0: r = 32'($signed($urandom_range(0, 31)) - 16);
      1: r = $urandom;
      2: r = boundaryImm[$urandom_range(0, 19)];
      3: r = $urandom << 12;
      4: r = 32'($signed($urandom_range(0, 2097151)) - 1048576) & 32'hFFFFFFFE;
      default: r = 32'($signed($urandom_range(0, 8191)) - 4096) & 32'hFFFFFFFE;
    endcase
    return r;
  endfunction

  initial begin
    boundaryImm = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4095, 32'd4096,
                    -32'sd4096, -32'sd4098, 32'd1048574, 32'd1048576, -32'sd1048576,
                    -32'sd1048578, 32'h1000, 32'h1001, 32'h0, 32'h1, 32'hFFFFFFFF,
                    32'h7FFFF000, 32'h80000000};
    rst = 1'b1; clearI = 1'b0; inValid = 1'b0; fmt = 3'd0; opcode = 7'h0; rd = 5'd0;
    rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0; funct7 = 7'd0; imm = 32'h0; wrReady = 1'b0;
    resetModel();
    repeat (2) @(negedge clk);
    checkOutput("reset_wr_valid", 32'(wrValid), 32'h0);
    checkOutput("reset_wr_data", wrData, 32'h0);
    checkOutput("reset_wr_addr", wrAddr, 32'h0);
    checkOutput("reset_wr_addr_wrap", 32'(wrAddrW), 32'hC);
    checkOutput("reset_err_cnt", 32'(errCnt), 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("reset_in_ready", 32'(inReady), 32'h1);
    @(negedge clk);
    checkAll();

    // I, B and J examples with known words
    applyStimulus(1'b1, 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
    checkOutput("tp_i_word", wrData, 32'hFFF00093);
    checkOutput("tp_i_addr", wrAddr, 32'h0);
    applyStimulus(1'b1, 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, 1'b1, 1'b0);
    checkOutput("tp_b_word", wrData, 32'hFE208EE3);
    applyStimulus(1'b1, 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1, 1'b0);
    checkOutput("tp_j_word", wrData, 32'h001000EF);
    idle(1'b1);

    // Range errors after a restart
    doClear();
    applyStimulus(1'b1, 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1001, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 1'b1, 1'b0);
    checkOutput("tp_err_pulse", 32'(err), 32'h1);
    idle(1'b1);
    checkOutput("tp_err_cnt", 32'(errCnt), 32'd4);
    checkOutput("tp_err_no_write", 32'(wrValid), 32'h0);
    checkOutput("tp_err_addr", wrAddr, 32'h0);

    // Backpressure: second request waits while the first is held
    applyStimulus(1'b1, 3'd0, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'd0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 3'd0, 7'h33, 5'd6, 5'd7, 5'd8, 3'd0, 7'h20, 32'h0, 1'b0, 1'b0);
      checkOutput("bp_held_addr", wrAddr, 32'h0);
      checkOutput("bp_in_ready", 32'(inReady), 32'h0);
    end
    applyStimulus(1'b1, 3'd0, 7'h33, 5'd6, 5'd7, 5'd8, 3'd0, 7'h20, 32'h0, 1'b1, 1'b0);
    checkOutput("bp_second_addr", wrAddr, 32'h4);
    idle(1'b1);

    // Streaming and address wrap on the narrow instance
    doClear();
    for (int i = 0; i < 6; i++) begin
      sendR(1'b1);
      checkOutput("stream_addr", wrAddr, 32'(4 * i));
    end
    idle(1'b1);
    doClear();
    sendR(1'b1);
    checkOutput("wrap_first", 32'(wrAddrW), 32'hC);
    sendR(1'b1);
    checkOutput("wrap_second", 32'(wrAddrW), 32'h0);
    idle(1'b1);

    // Clear with a pending word and a nonzero error count
    applyStimulus(1'b1, 3'd6, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 1'b0, 1'b0);
    sendR(1'b0);
    doClear();
    checkOutput("clear_valid", 32'(wrValid), 32'h0);
    checkOutput("clear_addr", wrAddr, 32'h0);
    checkOutput("clear_cnt", 32'(errCnt), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 7'($urandom),
                    5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
                    randImm(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
    end

    // Error counter saturation
    doClear();
    for (int i = 0; i < 270; i++) begin
      applyStimulus(1'b1, 3'd7, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 1'b1, 1'b0);
    end
    checkOutput("sat_cnt", 32'(errCnt), 32'd255);

    // Asynchronous reset with a word pending
    sendR(1'b0);
    #2 rst = 1'b1;
    #1;
    resetModel();
    checkOutput("async_rst_valid", 32'(wrValid), 32'h0);
    checkOutput("async_rst_data", wrData, 32'h0);
    checkOutput("async_rst_addr", wrAddr, 32'h0);
    checkOutput("async_rst_err", 32'(err), 32'h0);
    checkOutput("async_rst_cnt", 32'(errCnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    inValid = 1'b0;
    #1;
    checkAll();
    @(negedge clk);
    for (int i = 0; i < 4; i++) sendR(1'b1);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Packs RV32I instruction fields plus a 32-bit signed immediate into a 32-bit instruction word, the inverse of the decode-stage immediate extraction. The block also streams the encoded words into instruction memory through a write port with an auto-incrementing address. It sits between the boot/test loader and the instruction memory write port. The block checks immediate ranges and drops requests whose immediate cannot be encoded.

## Interface
- `DATA_WIDTH`, default 32: instruction and immediate width (fixed at 32; from `defines`).
- `ADDR_WIDTH`, default 32: write-address width.
- `BASE_ADDR`, default 0: first write address (must be a multiple of 4).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `clear_i` in 1: synchronous restart; sets the address to `BASE_ADDR`, zeroes `err_cnt_o`, and drops the pending word.
- `in_valid_i` in 1: request valid.
- `in_ready_o` out 1: block can accept a request.
- `fmt_i` in 3: format, 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- `opcode_i` in 7, `rd_i` in 5, `rs1_i` in 5, `rs2_i` in 5, `funct3_i` in 3, `funct7_i` in 7: instruction fields.
- `imm_i` in DATA_WIDTH: signed byte offset or value.
- `wr_valid_o` out 1: encoded word pending.
- `wr_ready_i` in 1: memory accepts the word.
- `wr_addr_o` out ADDR_WIDTH: write address.
- `wr_data_o` out DATA_WIDTH: encoded instruction.
- `err_o` out 1: one-cycle pulse when a request is dropped.
- `err_cnt_o` out 8: count of dropped requests; saturates at 255.

## Operation
- A request is accepted when `in_valid_i && in_ready_o`.
- `in_ready_o = !wr_valid_o || wr_ready_i`, so the next request can be accepted in the same cycle the pending word drains.
- Packing per format. Bits [6:0] always carry `opcode_i`.
  - R: funct7 at [31:25], rs2 at [24:20], rs1 at [19:15], funct3 at [14:12], rd at [11:7]. `imm_i` is ignored.
  - I: imm[11:0] at [31:20], then rs1, funct3, rd.
  - S: imm[11:5] at [31:25], rs2, rs1, funct3, imm[4:0] at [11:7].
  - B: imm[12] at [31], imm[10:5] at [30:25], rs2, rs1, funct3, imm[4:1] at [11:8], imm[11] at [7].
  - U: imm[31:12] at [31:12], then rd.
  - J: imm[20] at [31], imm[10:1] at [30:21], imm[11] at [20], imm[19:12] at [19:12], then rd.
- Fields not used by a format are ignored.
- Legality rules (the request is dropped if any rule fails):
  - I and S: `imm_i[31:11]` are all equal (12-bit signed range).
  - B: `imm_i[31:12]` are all equal, and `imm_i[0]` is 0.
  - J: `imm_i[31:20]` are all equal, and `imm_i[0]` is 0.
  - U: `imm_i[11:0]` is 0.
  - `fmt_i` of 6 or 7 is always illegal.
- Handling a dropped request:
  - It is still consumed from the input handshake.
  - `err_o` pulses in the next cycle, and `err_cnt_o` increments (saturating at 255).
  - No word is produced and the address does not advance.
  - Any pending word is unaffected.
- Address:
  - `wr_addr_o` holds the address of the current pending word.
  - After each completed write transfer (`wr_valid_o && wr_ready_i`) the address advances by 4, wrapping modulo 2^ADDR_WIDTH.
  - A legal request accepted in the same cycle as a transfer is written to the advanced address.
- `clear_i` has priority over every other event in that cycle. A request presented in the same cycle is not accepted: `in_ready_o` is 0 while `clear_i` is 1.
- Reset values: `wr_valid_o`=0, `wr_data_o`=0, `wr_addr_o`=`BASE_ADDR`, `err_o`=0, `err_cnt_o`=0. `in_ready_o` is 1 after reset deasserts.
- Asserting `rst` mid-stream discards the pending word with no partial write.

## Timing
- Latency is 1 cycle: a request accepted at edge N gives `wr_valid_o`=1 with `wr_data_o` valid after edge N.
- Peak throughput is 1 word/cycle while `wr_ready_i` stays high.
- While `wr_valid_o` is 1 and `wr_ready_i` is 0, `wr_data_o` and `wr_addr_o` hold stable and `in_ready_o` is 0.
- `err_o` is registered and asserts in the cycle after the dropped request is accepted.
- `wr_valid_o` deasserts after a transfer when no new legal request is accepted in the same cycle.

## Test plan
- I-format: `opcode_i`=0x13, `rd_i`=1, `rs1_i`=0, `funct3_i`=0, `imm_i`=-1 -> `wr_data_o`=0xFFF00093 at `wr_addr_o`=0x0 one cycle later.
- B-format: `opcode_i`=0x63, `rs1_i`=1, `rs2_i`=2, `funct3_i`=0, `imm_i`=-4 -> `wr_data_o`=0xFE208EE3. Then J-format: `opcode_i`=0x6F, `rd_i`=1, `imm_i`=2048 -> `wr_data_o`=0x001000EF.
- Range errors: I with `imm_i`=2048, B with `imm_i`=3, U with `imm_i`=0x1001, and `fmt_i`=7, each sent once -> `err_o` pulses 4 times, `err_cnt_o`=4, no writes, address stays 0x0.
- Backpressure: hold `wr_ready_i`=0 for 3 cycles while issuing 2 legal requests -> the first word is held stable, `in_ready_o`=0, the second request waits. After release, the two words go out at addresses 0x0 and 0x4 in consecutive cycles.
- Streaming: `wr_ready_i`=1, 6 back-to-back legal requests -> addresses 0x0 through 0x14, one per cycle. Then with `ADDR_WIDTH`=4, `BASE_ADDR`=0xC, two writes -> addresses 0xC then 0x0 (wrap).
- Clear and reset: `clear_i` with a pending word -> `wr_valid_o`=0, `wr_addr_o`=`BASE_ADDR`, `err_cnt_o`=0. Assert `rst` asynchronously mid-cycle -> all outputs at their reset values immediately.
